// File: rtl/ipv4_top_hls_deadlock_report_ctrl.sv
// ipv4_top_hls_deadlock_report_ctrl: debounces unit deadlock detects, launches/retires the report token, latches the report.
// Optional token watchdog enabled by defining DL_TOKEN_TIMEOUT_EN.
module ipv4_top_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM       = 4,
    parameter int PERSIST_CYCLES = 8,
    parameter int TOKEN_TIMEOUT  = 64,
    localparam int IDX_W         = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_in_vec,
    input  logic [PROC_NUM-1:0] token_ret_vec,
    input  logic                report_clear,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                ap_deadlock,
    output logic [IDX_W-1:0]    dl_proc_idx,
    output logic [PROC_NUM-1:0] dl_chain_vec
`ifdef DL_TOKEN_TIMEOUT_EN
    ,
    output logic                dl_abort
`endif
);
    localparam int CNT_W = $clog2(PERSIST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, QUALIFY, LAUNCH, CIRCULATE, REPORT} state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n, low_idx;
    logic [CNT_W-1:0]    cnt;
    logic [PROC_NUM-1:0] chain;
    logic                cnt_last, ret_hit;
`ifdef DL_TOKEN_TIMEOUT_EN
    logic [15:0]         tcnt;
    logic                t_expired;
    assign t_expired = tcnt == 16'(TOKEN_TIMEOUT - 1);
`endif

    assign cnt_last = cnt == CNT_W'(PERSIST_CYCLES - 1);
    assign ret_hit  = state == CIRCULATE && token_ret_vec[idx];
    assign idx_n    = (state == IDLE && |dl_detect_in_vec) ? low_idx : idx;

    always_comb begin
        low_idx = '0;
        for (int p = PROC_NUM - 1; p >= 0; p--)
            if (dl_detect_in_vec[p]) low_idx = IDX_W'(p);
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n     = state;
        token_clear = 1'b0;
        case (state)
            IDLE:      state_n = !(|dl_detect_in_vec) ? IDLE : (PERSIST_CYCLES == 1) ? LAUNCH : QUALIFY;
            QUALIFY:   state_n = !dl_detect_in_vec[idx] ? IDLE : cnt_last ? LAUNCH : QUALIFY;
            LAUNCH:    state_n = CIRCULATE;
            CIRCULATE: begin
                if (token_ret_vec[idx]) begin
                    token_clear = 1'b1;
                    state_n     = REPORT;
                end
`ifdef DL_TOKEN_TIMEOUT_EN
                else if (t_expired) begin
                    token_clear = 1'b1;
                    state_n     = IDLE;
                end
`endif
            end
            REPORT:    state_n = report_clear ? IDLE : REPORT;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            idx           <= '0;
            cnt           <= '0;
            chain         <= '0;
            dl_detect_out <= 1'b0;
            origin_vec    <= '0;
            ap_deadlock   <= 1'b0;
            dl_proc_idx   <= '0;
            dl_chain_vec  <= '0;
        end else begin
            idx           <= idx_n;
            dl_detect_out <= state_n != IDLE;
            origin_vec    <= (state_n == LAUNCH) ? PROC_NUM'(1) << idx_n : '0;
            if (state == IDLE && |dl_detect_in_vec)
                cnt <= CNT_W'(1);
            else if (state == QUALIFY)
                cnt <= dl_detect_in_vec[idx] ? cnt + 1'b1 : '0;
            if (state == LAUNCH)
                chain <= PROC_NUM'(1) << idx;
            else if (state == CIRCULATE)
                chain <= chain | token_ret_vec;
            // The report includes the bits seen on the returning cycle itself
            if (ret_hit) begin
                ap_deadlock  <= 1'b1;
                dl_proc_idx  <= idx;
                dl_chain_vec <= chain | token_ret_vec;
            end else if (state == REPORT && report_clear) begin
                ap_deadlock  <= 1'b0;
                dl_proc_idx  <= '0;
                dl_chain_vec <= '0;
            end
        end

`ifdef DL_TOKEN_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            tcnt     <= '0;
            dl_abort <= 1'b0;
        end else begin
            tcnt     <= (state == CIRCULATE) ? tcnt + 16'd1 : '0;
            dl_abort <= state == CIRCULATE && !token_ret_vec[idx] && t_expired;
        end
`endif
endmodule

// File: tb/tb_ipv4_top_hls_deadlock_report_ctrl.sv
// tb_ipv4_top_hls_deadlock_report_ctrl: directed checks of qualification, token circulation, report and reset.
module tb_ipv4_top_hls_deadlock_report_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] dl_detect_in_vec = '0;
    logic [3:0] token_ret_vec = '0;
    logic       report_clear = 1'b0;
    logic       dl_detect_out, token_clear, ap_deadlock;
    logic [3:0] origin_vec, dl_chain_vec;
    logic [1:0] dl_proc_idx;
`ifdef DL_TOKEN_TIMEOUT_EN
    logic       dl_abort;
`endif
    int checks = 0;
    int failures = 0;

    ipv4_top_hls_deadlock_report_ctrl dut (
        .clock(clock), .reset(reset),
        .dl_detect_in_vec(dl_detect_in_vec), .token_ret_vec(token_ret_vec),
        .report_clear(report_clear), .dl_detect_out(dl_detect_out),
        .origin_vec(origin_vec), .token_clear(token_clear),
        .ap_deadlock(ap_deadlock), .dl_proc_idx(dl_proc_idx),
        .dl_chain_vec(dl_chain_vec)
`ifdef DL_TOKEN_TIMEOUT_EN
        , .dl_abort(dl_abort)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic qualify(input logic [3:0] det, input logic [31:0] onehot, input string tag);
        dl_detect_in_vec = det;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk(tag, 32'(origin_vec), (i == 8) ? onehot : 32'h0);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_dod", 32'(dl_detect_out), 0);
        chk("rst_origin", 32'(origin_vec), 0);
        chk("rst_tc", 32'(token_clear), 0);
        chk("rst_ap", 32'(ap_deadlock), 0);
        chk("rst_idx", 32'(dl_proc_idx), 0);
        chk("rst_chain", 32'(dl_chain_vec), 0);
        reset = 1'b1;
        // T2: qualify unit 2, token visits 1 and 3 before returning
        qualify(4'b0100, 32'h4, "t2_origin");
        chk("t2_dod", 32'(dl_detect_out), 1);
        tick();
        chk("t2_origin_pulse", 32'(origin_vec), 0);
        token_ret_vec = 4'b0010;
        #1 chk("t2_tc_early", 32'(token_clear), 0);
        tick();
        token_ret_vec = 4'b1000;
        tick();
        token_ret_vec = 4'b0100;
        #1 chk("t2_tc", 32'(token_clear), 1);
        tick();
        token_ret_vec = '0;
        #1;
        chk("t2_ap", 32'(ap_deadlock), 1);
        chk("t2_idx", 32'(dl_proc_idx), 2);
        chk("t2_chain", 32'(dl_chain_vec), 32'he);
        chk("t2_tc_off", 32'(token_clear), 0);
        tick();
        chk("t2_hold_ap", 32'(ap_deadlock), 1);
        chk("t2_hold_dod", 32'(dl_detect_out), 1);
        // T5: clear with detect still active, then full requalification and self-loop
        report_clear = 1'b1;
        tick();
        report_clear = 1'b0;
        chk("t5_ap", 32'(ap_deadlock), 0);
        chk("t5_chain", 32'(dl_chain_vec), 0);
        chk("t5_idx", 32'(dl_proc_idx), 0);
        chk("t5_dod", 32'(dl_detect_out), 0);
        qualify(4'b0100, 32'h4, "t5_origin");
        tick();
        token_ret_vec = 4'b0100;
        #1 chk("t5_self_tc", 32'(token_clear), 1);
        tick();
        token_ret_vec = '0;
        chk("t5_self_chain", 32'(dl_chain_vec), 32'h4);
        chk("t5_self_ap", 32'(ap_deadlock), 1);
        dl_detect_in_vec = '0;
        report_clear = 1'b1;
        tick();
        report_clear = 1'b0;
        chk("t5_idle_dod", 32'(dl_detect_out), 0);
        // T3: detect drops during qualification
        dl_detect_in_vec = 4'b0100;
        repeat (5) tick();
        dl_detect_in_vec = '0;
        chk("t3_dod_on", 32'(dl_detect_out), 1);
        tick();
        chk("t3_dod_off", 32'(dl_detect_out), 0);
        repeat (10) tick();
        chk("t3_no_origin", 32'(origin_vec), 0);
        chk("t3_ap", 32'(ap_deadlock), 0);
        // T4: simultaneous detects, lowest index wins
        qualify(4'b1010, 32'h2, "t4_origin");
        tick();
        token_ret_vec = 4'b0001;
        tick();
        token_ret_vec = 4'b0010;
        #1 chk("t4_tc", 32'(token_clear), 1);
        tick();
        token_ret_vec = '0;
        chk("t4_idx", 32'(dl_proc_idx), 1);
        chk("t4_chain", 32'(dl_chain_vec), 32'h3);
        // T1: reset asserted mid-circulation
        report_clear = 1'b1;
        tick();
        report_clear = 1'b0;
        repeat (8) tick();
        chk("t1_origin", 32'(origin_vec), 32'h2);
        tick();
        token_ret_vec = 4'b0001;
        tick();
        token_ret_vec = 4'b0010;
        reset = 1'b0;
        #1;
        chk("t1_tc", 32'(token_clear), 0);
        chk("t1_dod", 32'(dl_detect_out), 0);
        chk("t1_origin_rst", 32'(origin_vec), 0);
        chk("t1_ap", 32'(ap_deadlock), 0);
        dl_detect_in_vec = '0;
        token_ret_vec = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("t1_idle_dod", 32'(dl_detect_out), 0);
        chk("t1_idle_chain", 32'(dl_chain_vec), 0);
`ifdef DL_TOKEN_TIMEOUT_EN
        // T6: token never returns
        qualify(4'b0100, 32'h4, "t6_origin");
        dl_detect_in_vec = '0;
        tick();
        for (int i = 1; i < 64; i++) begin
            chk("t6_tc_wait", 32'(token_clear), 0);
            tick();
        end
        chk("t6_tc", 32'(token_clear), 1);
        tick();
        chk("t6_abort", 32'(dl_abort), 1);
        chk("t6_ap", 32'(ap_deadlock), 0);
        chk("t6_dod", 32'(dl_detect_out), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
